dbi_tx_phy: RTL

- Physical-layer stage of the DBI transmitter. It sits directly downstream of the DBI TX command/stream FSM.
- Accepts command/data beats over a valid/ready handshake and serialises them onto a MIPI DBI Type-B (8080-style, write-only) parallel bus: CSX, DCX, WRX, RDX, D[7:0].
- Write-strobe timing is set by parameters, counted in system clock cycles.

---
 rtl/dbi_tx_pkg.sv | 40 ++++
 rtl/dbi_tx_phy_if.sv | 35 +++
 rtl/dbi_tx_phy.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dbi_tx_pkg.sv
// -----------------------------------------------------------------------------
// dbi_tx_pkg
// Shared definitions for the DBI transmitter: PHY state encoding, default
// strobe timing, and the DCX level constants. The upstream command/stream FSM
// imports the same package so both sides agree on DCX polarity.
// -----------------------------------------------------------------------------
package dbi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CMD_WL   = 3'd2,
        ST_CMD_WH   = 3'd3,
        ST_DAT_WL   = 3'd4,
        ST_DAT_WH   = 3'd5,
        ST_NEXT     = 3'd6,
        ST_CS_HOLD  = 3'd7
    } dbi_tx_state_e;

    localparam int unsigned DEF_DBI_IF_D_W   = 8;
    localparam int unsigned DEF_CS_SETUP_CYC = 1;
    localparam int unsigned DEF_WR_LOW_CYC   = 2;
    localparam int unsigned DEF_WR_HIGH_CYC  = 2;
    localparam int unsigned DEF_CS_HOLD_CYC  = 1;
    localparam int unsigned DEF_CNT_W        = 8;

    localparam logic DCX_CMD = 1'b0;
    localparam logic DCX_DAT = 1'b1;

    // States in which the PHY can take a new beat.
    function automatic logic st_accepts(dbi_tx_state_e s);
        return (s == ST_IDLE) || (s == ST_NEXT);
    endfunction

    // States that drive WRX low.
    function automatic logic st_wr_low(dbi_tx_state_e s);
        return (s == ST_CMD_WL) || (s == ST_DAT_WL);
    endfunction

endpackage

// File: rtl/dbi_tx_phy_if.sv
// -----------------------------------------------------------------------------
// dbi_tx_phy_if
// Beat handshake between the DBI TX command/stream FSM (master) and the PHY
// (slave). Signal names carry the PHY-side direction suffix.
//   dtp_tx_cmd_typ_i : DCS command byte (sent with DCX=0)
//   dtp_tx_cmd_dat_i : parameter/pixel byte (sent with DCX=1)
//   dtp_tx_last_i    : final beat of the transaction
//   dtp_tx_vld_i     : beat valid
//   dtp_tx_rdy_o     : PHY can accept a beat
// -----------------------------------------------------------------------------
interface dbi_tx_phy_if #(
    parameter int unsigned DBI_IF_D_W = 8
);
    logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_i;
    logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_i;
    logic                  dtp_tx_last_i;
    logic                  dtp_tx_vld_i;
    logic                  dtp_tx_rdy_o;

    modport master (
        output dtp_tx_cmd_typ_i,
        output dtp_tx_cmd_dat_i,
        output dtp_tx_last_i,
        output dtp_tx_vld_i,
        input  dtp_tx_rdy_o
    );

    modport slave (
        input  dtp_tx_cmd_typ_i,
        input  dtp_tx_cmd_dat_i,
        input  dtp_tx_last_i,
        input  dtp_tx_vld_i,
        output dtp_tx_rdy_o
    );
endinterface

// File: rtl/dbi_tx_phy.sv
// -----------------------------------------------------------------------------
// dbi_tx_phy
// Serialises command/data beats onto a MIPI DBI Type-B (8080, write-only)
// parallel bus. WRX strobe and CSX framing widths are parameterised in clock
// cycles and timed by a single down-counter.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   up          : beat handshake (dbi_tx_phy_if.slave)
//   dbi_csx_o   : chip select, active low
//   dbi_dcx_o   : 0 = command, 1 = data
//   dbi_wrx_o   : write strobe (display latches on rising edge)
//   dbi_rdx_o   : read strobe, tied high
//   dbi_d_o     : bus data
//   dbi_busy_o  : high whenever not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module dbi_tx_phy
    import dbi_tx_pkg::*;
#(
    parameter int unsigned DBI_IF_D_W   = DEF_DBI_IF_D_W,
    parameter int unsigned CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int unsigned WR_LOW_CYC   = DEF_WR_LOW_CYC,
    parameter int unsigned WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
    parameter int unsigned CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dbi_tx_phy_if.slave           up,
    output logic                  dbi_csx_o,
    output logic                  dbi_dcx_o,
    output logic                  dbi_wrx_o,
    output logic                  dbi_rdx_o,
    output logic [DBI_IF_D_W-1:0] dbi_d_o,
    output logic                  dbi_busy_o
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LOW   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HIGH  = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD_CYC - 1);

    dbi_tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DBI_IF_D_W-1:0] typ_q, dat_q;
    logic                  last_q;

    logic                  csx_q, csx_d;
    logic                  dcx_q, dcx_d;
    logic                  wrx_q, wrx_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;
    logic [DBI_IF_D_W-1:0] d_q, d_d;

    logic                  accept;
    logic                  cnt_done;
    logic [DBI_IF_D_W-1:0] dat_src;

    function automatic logic [CNT_W-1:0] phase_load(dbi_tx_state_e s);
        case (s)
            ST_CS_SETUP:          return LD_SETUP;
            ST_CMD_WL, ST_DAT_WL: return LD_LOW;
            ST_CMD_WH, ST_DAT_WH: return LD_HIGH;
            ST_CS_HOLD:           return LD_HOLD;
            default:              return '0;
        endcase
    endfunction

    assign accept   = up.dtp_tx_vld_i & rdy_q;
    assign cnt_done = (cnt_q == '0);
    // A beat accepted in NEXT goes straight to DAT_WL, so its byte must be
    // taken from the port rather than the (not yet updated) latch.
    assign dat_src  = accept ? up.dtp_tx_cmd_dat_i : dat_q;

    // Next-state and timing counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE:     if (accept)   state_d = ST_CS_SETUP;
            ST_CS_SETUP: if (cnt_done) state_d = ST_CMD_WL;
            ST_CMD_WL:   if (cnt_done) state_d = ST_CMD_WH;
            ST_CMD_WH:   if (cnt_done) state_d = last_q ? ST_CS_HOLD : ST_DAT_WL;
            ST_DAT_WL:   if (cnt_done) state_d = ST_DAT_WH;
            ST_DAT_WH:   if (cnt_done) state_d = last_q ? ST_CS_HOLD : ST_NEXT;
            ST_NEXT:     if (accept)   state_d = ST_DAT_WL;
            ST_CS_HOLD:  if (cnt_done) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase

        // No state re-enters itself, so a state change is a phase entry.
        if (state_d != state_q) begin
            cnt_d = phase_load(state_d);
        end else if (!cnt_done) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Output next values derived from the next state, so the registered
    // outputs line up with the state they belong to.
    always_comb begin
        csx_d  = (state_d == ST_IDLE);
        wrx_d  = ~st_wr_low(state_d);
        rdy_d  = st_accepts(state_d);
        busy_d = (state_d != ST_IDLE);
        dcx_d  = dcx_q;
        d_d    = d_q;

        if (state_d == ST_IDLE) begin
            dcx_d = DCX_DAT;
            d_d   = '0;
        end else if (state_d != state_q) begin
            if (state_d == ST_CMD_WL) begin
                dcx_d = DCX_CMD;
                d_d   = typ_q;
            end else if (state_d == ST_DAT_WL) begin
                dcx_d = DCX_DAT;
                d_d   = dat_src;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            typ_q   <= '0;
            dat_q   <= '0;
            last_q  <= 1'b0;
            csx_q   <= 1'b1;
            dcx_q   <= 1'b1;
            wrx_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                typ_q  <= up.dtp_tx_cmd_typ_i;
                dat_q  <= up.dtp_tx_cmd_dat_i;
                last_q <= up.dtp_tx_last_i;
            end
            csx_q   <= csx_d;
            dcx_q   <= dcx_d;
            wrx_q   <= wrx_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            d_q     <= d_d;
        end
    end

    assign up.dtp_tx_rdy_o = rdy_q;
    assign dbi_csx_o       = csx_q;
    assign dbi_dcx_o       = dcx_q;
    assign dbi_wrx_o       = wrx_q;
    assign dbi_rdx_o       = 1'b1;
    assign dbi_d_o         = d_q;
    assign dbi_busy_o      = busy_q;

endmodule
